// File: rtl/adc_ro_pkg.sv
// Shared types for the multichannel ADC column-readout sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adc_ro_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_CP,
      CAPTURE,
      EMIT,
      WAIT_CP_LOW
   } state_t;

   // Marker placed in the upper half of the optional per-column header beat
   localparam logic [15:0] HDR_MAGIC = 16'hC0DE;

endpackage

// File: rtl/adc_ro_multich_if.sv
// ADC capture side plus the channel-packed output stream of the readout sequencer.
// Latency: n/a (wiring only).
// Backpressure: out_ready from the consumer stalls the stream; the ADC side has none.
interface adc_ro_multich_if #(
   parameter int N_CH = 2,
   parameter int DW   = 16
);
   logic [N_CH*DW-1:0] adc_data;
   logic [N_CH-1:0]    adc_valid;
   logic               adc_en;
   logic [N_CH*DW-1:0] out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;

   // Sequencer side
   modport master (
      input  adc_data, adc_valid, out_ready,
      output adc_en, out_data, out_valid, out_last
   );

   // ADC source / stream consumer side
   modport slave (
      output adc_data, adc_valid, out_ready,
      input  adc_en, out_data, out_valid, out_last
   );
endinterface

// File: rtl/adc_ro_ch_buf.sv
// Per-channel sample store: counts and holds up to SAMPLES words, flags strobes arriving when full.
// Latency: a word is readable one cycle after its strobe; read port is combinational by index.
// Backpressure: none; strobes while full are dropped and reported on overrun (same cycle).
module adc_ro_ch_buf #(
   parameter int DW      = 16,
   parameter int SAMPLES = 3,
   parameter int CW      = $clog2(SAMPLES + 1)
) (
   input  logic          clk_100,
   input  logic          rst,
   input  logic          clr,
   input  logic          capture,
   input  logic          strobe,
   input  logic [DW-1:0] sample,
   input  logic [CW-1:0] rd_idx,
   output logic [DW-1:0] rd_word,
   output logic          full,
   output logic          overrun
);

   logic [CW-1:0] cnt;
   logic [DW-1:0] mem [SAMPLES];

   assign full    = (cnt == CW'(SAMPLES));
   assign overrun = capture & strobe & full;
   assign rd_word = mem[rd_idx];

   // Store accepted samples in arrival order; counter is cleared at the start of each column
   always_ff @(posedge clk_100) begin
      if (rst) begin
         cnt <= '0;
         for (int i = 0; i < SAMPLES; i++) mem[i] <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (capture && strobe && !full) begin
         mem[cnt] <= sample;
         cnt      <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/adc_ro_multich.sv
// Column-readout sequencer: per column pulse captures SAMPLES words per ADC channel, then streams them channel-packed.
// Latency: first beat valid 2 cycles after the last channel's final strobe; one beat per accepted handshake.
// Backpressure: out_ready low holds out_data/out_valid stable; ADC side is not stalled (overrun flagged instead).
// Optional feature: define ADC_RO_HDR_EN to prefix each column with a {HDR_MAGIC, col_idx} header beat.
module adc_ro_multich
   import adc_ro_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int DW      = 16,
   parameter int SAMPLES = 3,
   parameter int COL_NUM = 43,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk_100,
   input  logic              rst,
   input  logic              mux_start,
   input  logic              cp_mux_in,
   adc_ro_multich_if.master  bus,
   output logic              busy,
   output logic [15:0]       col_idx,
   output logic              err_overrun,
   output logic              err_timeout
);

   localparam int CW = $clog2(SAMPLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
`ifdef ADC_RO_HDR_EN
   localparam int NB = SAMPLES + 1;
`else
   localparam int NB = SAMPLES;
`endif
   localparam int BW = $clog2(NB + 1);

`ifdef ADC_RO_HDR_EN
   generate
      if (N_CH * DW < 32) begin : g_hdr_width_chk
         $error("adc_ro_multich: header beat needs N_CH*DW >= 32");
      end
   endgenerate
`endif

   state_t             state, state_nxt;
   logic               cp_q;
   logic               cp_rise;
   logic [TW-1:0]      timer;
   logic [BW-1:0]      beat;
   logic [CW-1:0]      rd_idx;
   logic [N_CH-1:0]    full;
   logic [N_CH-1:0]    overrun;
   logic [DW-1:0]      rd_word [N_CH];
   logic               all_full;
   logic               timed_out;
   logic               last_beat;
   logic               last_col;
   logic [N_CH*DW-1:0] data_beat;

   assign cp_rise   = cp_mux_in & ~cp_q;
   assign all_full  = &full;
   assign timed_out = (state == CAPTURE) && !all_full && (timer == TW'(TIMEOUT - 1));
   assign last_beat = (beat == BW'(NB - 1));
   assign last_col  = (col_idx == 16'(COL_NUM - 1));

   generate
      for (genvar c = 0; c < N_CH; c++) begin : g_ch
         adc_ro_ch_buf #(.DW(DW), .SAMPLES(SAMPLES)) u_buf (
            .clk_100 (clk_100),
            .rst     (rst),
            .clr     ((state == WAIT_CP) && cp_rise),
            .capture (state == CAPTURE),
            .strobe  (bus.adc_valid[c]),
            .sample  (bus.adc_data[c*DW +: DW]),
            .rd_idx  (rd_idx),
            .rd_word (rd_word[c]),
            .full    (full[c]),
            .overrun (overrun[c])
         );
      end
   endgenerate

   // State register
   always_ff @(posedge clk_100) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; a finished column waits for the pulse to drop so a long pulse cannot retrigger
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (mux_start) state_nxt = WAIT_CP;
         WAIT_CP:     if (cp_rise) state_nxt = CAPTURE;
         CAPTURE: begin
            if (all_full)       state_nxt = EMIT;
            else if (timed_out) state_nxt = IDLE;
         end
         EMIT:        if (bus.out_ready && last_beat) state_nxt = last_col ? IDLE : WAIT_CP_LOW;
         WAIT_CP_LOW: if (!cp_mux_in) state_nxt = WAIT_CP;
         default:     state_nxt = IDLE;
      endcase
   end

   // Edge detector, capture timer, beat/column counters and sticky error flags
   always_ff @(posedge clk_100) begin
      if (rst) begin
         cp_q        <= 1'b0;
         timer       <= '0;
         beat        <= '0;
         col_idx     <= '0;
         err_overrun <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         cp_q  <= cp_mux_in;
         timer <= (state == CAPTURE) ? timer + TW'(1) : '0;
         if ((state == IDLE) && mux_start) begin
            col_idx     <= '0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
         end
         if (|overrun)  err_overrun <= 1'b1;
         if (timed_out) err_timeout <= 1'b1;
         if ((state == EMIT) && bus.out_ready) begin
            if (last_beat) begin
               beat <= '0;
               if (!last_col) col_idx <= col_idx + 16'd1;
            end else begin
               beat <= beat + BW'(1);
            end
         end
      end
   end

   // Stream outputs decoded from state; data is zero outside EMIT so reset leaves every output low
   always_comb begin
      data_beat = '0;
      for (int c = 0; c < N_CH; c++) data_beat[c*DW +: DW] = rd_word[c];
`ifdef ADC_RO_HDR_EN
      rd_idx = (beat == '0) ? '0 : CW'(beat - BW'(1));
`else
      rd_idx = CW'(beat);
`endif
      bus.out_data = '0;
      if (state == EMIT) begin
`ifdef ADC_RO_HDR_EN
         if (beat == '0) begin
            bus.out_data[15:0]  = col_idx;
            bus.out_data[31:16] = HDR_MAGIC;
         end else begin
            bus.out_data = data_beat;
         end
`else
         bus.out_data = data_beat;
`endif
      end
      bus.adc_en    = (state == CAPTURE);
      bus.out_valid = (state == EMIT);
      bus.out_last  = (state == EMIT) && last_beat && last_col;
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_adc_ro_multich.sv
// Scoreboard bench for adc_ro_multich: directed columns push expected beats, a monitor pops on each handshake.
// Latency: n/a.
// Backpressure: exercised by holding out_ready low during EMIT.
module tb_adc_ro_multich;

   localparam int N_CH = 2;
   localparam int DW   = 16;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } exp_t;

   logic        clk_100 = 1'b0;
   logic        rst, mux_start, cp_mux_in;
   logic        busy, err_overrun, err_timeout;
   logic [15:0] col_idx;
   logic        t_mux_start, t_cp, t_busy, t_err_ov, t_err_to;
   logic [15:0] t_col_idx;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk_100 = ~clk_100;

   adc_ro_multich_if #(.N_CH(N_CH), .DW(DW)) bus ();
   adc_ro_multich_if #(.N_CH(N_CH), .DW(DW)) tbus ();

   adc_ro_multich #(.N_CH(N_CH), .DW(DW), .SAMPLES(3), .COL_NUM(2), .TIMEOUT(64)) dut (
      .clk_100(clk_100), .rst(rst), .mux_start(mux_start), .cp_mux_in(cp_mux_in), .bus(bus),
      .busy(busy), .col_idx(col_idx), .err_overrun(err_overrun), .err_timeout(err_timeout)
   );

   adc_ro_multich #(.N_CH(N_CH), .DW(DW), .SAMPLES(3), .COL_NUM(2), .TIMEOUT(16)) dut_to (
      .clk_100(clk_100), .rst(rst), .mux_start(t_mux_start), .cp_mux_in(t_cp), .bus(tbus),
      .busy(t_busy), .col_idx(t_col_idx), .err_overrun(t_err_ov), .err_timeout(t_err_to)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk_100);
      #1;
   endtask

   task automatic start_frame();
      mux_start = 1'b1;
      tick();
      mux_start = 1'b0;
   endtask

   task automatic col_pulse();
      cp_mux_in = 1'b1;
      tick();
      tick();
      cp_mux_in = 1'b0;
   endtask

   task automatic strobe(input logic [1:0] m, input logic [15:0] d0, input logic [15:0] d1);
      bus.adc_valid = m;
      bus.adc_data  = {d1, d0};
      tick();
      bus.adc_valid = 2'b00;
   endtask

   task automatic push(input logic [15:0] d0, input logic [15:0] d1, input logic last);
      exp_t e;
      e.data = {d1, d0};
      e.last = last;
      sb.push_back(e);
   endtask

   task automatic push_hdr(input logic [15:0] col);
`ifdef ADC_RO_HDR_EN
      push(col, 16'hC0DE, 1'b0);
`else
      if (col > 16'd1) $display("note: unexpected column %0d", col);
`endif
   endtask

   // Both channels strobe together with b0+k / b1+k
   task automatic do_col(input logic [15:0] col, input logic [15:0] b0, input logic [15:0] b1, input logic last_col);
      push_hdr(col);
      for (int k = 0; k < 3; k++) begin
         strobe(2'b11, b0 + 16'(k), b1 + 16'(k));
         push(b0 + 16'(k), b1 + 16'(k), last_col && (k == 2));
      end
   endtask

   task automatic wait_valid(input string name, input int budget);
      int n;
      n = 0;
      while (!bus.out_valid && n < budget) begin
         tick();
         n++;
      end
      check(name, {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check(name, sb.size(), 32'd0);
      tick();
      tick();
   endtask

   // Monitor: checks every accepted beat against the scoreboard and stability while stalled
   initial begin
      logic        stalled;
      logic [31:0] held;
      exp_t        e;
      stalled = 1'b0;
      held    = '0;
      forever begin
         @(negedge clk_100);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
               check("stall_data", bus.out_data, held);
            end
            if (bus.out_valid && bus.out_ready) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_beat: got %h want none", bus.out_data);
               end else begin
                  e = sb.pop_front();
                  check("beat_data", bus.out_data, e.data);
                  check("beat_last", {31'd0, bus.out_last}, {31'd0, e.last});
               end
               stalled = 1'b0;
            end else if (bus.out_valid) begin
               stalled = 1'b1;
               held    = bus.out_data;
            end else begin
               stalled = 1'b0;
            end
         end
      end
   end

   initial begin
      int cnt;
      rst = 1'b1; mux_start = 1'b0; cp_mux_in = 1'b0;
      bus.adc_valid = '0; bus.adc_data = '0; bus.out_ready = 1'b1;
      t_mux_start = 1'b0; t_cp = 1'b0;
      tbus.adc_valid = '0; tbus.adc_data = '0; tbus.out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_adc_en", {31'd0, bus.adc_en}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_col_idx", {16'd0, col_idx}, 32'd0);

      // Full two-column frame, six beats, last on the sixth
      start_frame();
      check("start_busy", {31'd0, busy}, 32'd1);
      col_pulse();
      check("cap_adc_en", {31'd0, bus.adc_en}, 32'd1);
      do_col(16'd0, 16'hA000, 16'hB000, 1'b0);
      drain("f1_col0_drain", 50);
      col_pulse();
      do_col(16'd1, 16'hA010, 16'hB010, 1'b1);
      drain("f1_col1_drain", 50);
      check("f1_idle_busy", {31'd0, busy}, 32'd0);
      check("f1_col_idx", {16'd0, col_idx}, 32'd1);

      // ch1 delayed 20 cycles: adc_en held, nothing emitted early
      start_frame();
      col_pulse();
      push_hdr(16'd0);
      for (int k = 0; k < 3; k++) strobe(2'b01, 16'h1000 + 16'(k), 16'h0000);
      repeat (20) tick();
      check("delay_adc_en", {31'd0, bus.adc_en}, 32'd1);
      check("delay_no_valid", {31'd0, bus.out_valid}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         strobe(2'b10, 16'h0000, 16'h2000 + 16'(k));
         push(16'h1000 + 16'(k), 16'h2000 + 16'(k), 1'b0);
      end
      drain("delay_drain", 50);

      // Stall: out_ready low for 10 cycles in EMIT
      bus.out_ready = 1'b0;
      col_pulse();
      do_col(16'd1, 16'h5550, 16'h6660, 1'b1);
      wait_valid("stall_wait_valid", 20);
      repeat (10) tick();
      bus.out_ready = 1'b1;
      drain("stall_drain", 50);
      check("stall_err_ov", {31'd0, err_overrun}, 32'd0);
      check("stall_err_to", {31'd0, err_timeout}, 32'd0);

      // Overrun: 4th strobe on ch1 is dropped and flagged
      start_frame();
      col_pulse();
      push_hdr(16'd0);
      for (int k = 0; k < 3; k++) strobe(2'b10, 16'h0000, 16'h3000 + 16'(k));
      check("ov_before", {31'd0, err_overrun}, 32'd0);
      strobe(2'b10, 16'h0000, 16'hDEAD);
      check("ov_set", {31'd0, err_overrun}, 32'd1);
      for (int k = 0; k < 3; k++) begin
         strobe(2'b01, 16'h4000 + 16'(k), 16'h0000);
         push(16'h4000 + 16'(k), 16'h3000 + 16'(k), 1'b0);
      end
      drain("ov_drain0", 50);
      col_pulse();
      do_col(16'd1, 16'h7000, 16'h8000, 1'b1);
      drain("ov_drain1", 50);
      check("ov_sticky", {31'd0, err_overrun}, 32'd1);
      start_frame();
      check("ov_cleared", {31'd0, err_overrun}, 32'd0);

      // Reset while stalled in EMIT: everything returns to zero, no flush
      bus.out_ready = 1'b0;
      col_pulse();
      for (int k = 0; k < 3; k++) strobe(2'b11, 16'h9000, 16'h9100);
      wait_valid("rst_emit_valid", 20);
      rst = 1'b1;
      tick();
      tick();
      check("rst2_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst2_data", bus.out_data, 32'd0);
      check("rst2_last", {31'd0, bus.out_last}, 32'd0);
      check("rst2_busy", {31'd0, busy}, 32'd0);
      check("rst2_adc_en", {31'd0, bus.adc_en}, 32'd0);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      tick();

      // Timeout instance: ch1 never strobes, abort after 16 CAPTURE cycles
      t_mux_start = 1'b1;
      tick();
      t_mux_start = 1'b0;
      t_cp = 1'b1;
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_100);
         if (i == 2) t_cp = 1'b0;
         tbus.adc_valid = (cnt >= 1 && cnt <= 3) ? 2'b01 : 2'b00;
         tbus.adc_data  = {16'h0000, 16'hCC00 + 16'(cnt)};
         if (tbus.adc_en) cnt++;
         else if (cnt > 0) break;
      end
      tbus.adc_valid = 2'b00;
      check("to_cycles", cnt, 32'd16);
      check("to_err", {31'd0, t_err_to}, 32'd1);
      check("to_adc_en", {31'd0, tbus.adc_en}, 32'd0);
      check("to_busy", {31'd0, t_busy}, 32'd0);
      check("to_no_valid", {31'd0, tbus.out_valid}, 32'd0);
      check("to_no_ov", {15'd0, t_err_ov, t_col_idx}, 32'd0);

      tick();
      check("final_sb_empty", sb.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
